// File: rtl/gcd_sched_pkg.sv
// Shared types and constants for the arbitrated GCD server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_t   : scheduler state encoding
//   DEF_WIDTH : default operand/result width
//   tag_w()   : width of the requester index tag
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_sched_if.sv
// Request/response bundle between GCD clients and the scheduler.
// Latency: n/a (wires only).
// Backpressure: req_ready grants one requester; rsp_ready stalls the result.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake (packed i*WIDTH)
//   rsp_valid/rsp_id/rsp_gcd/rsp_ready : tagged result handshake
//   busy : scheduler not idle
interface gcd_sched_if
  import gcd_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WIDTH-1:0]  req_a;
  logic [N_REQ*WIDTH-1:0]  req_b;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [tag_w(N_REQ)-1:0] rsp_id;
  logic [WIDTH-1:0]        rsp_gcd;
  logic                    rsp_ready;
  logic                    busy;

  // Client side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gcd, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gcd, busy
  );

endinterface

// File: rtl/gcd_sched_core.sv
// Iterative subtractive-Euclid GCD engine (gcd_core).
// Latency: load edge T, done pulse visible after edge T+1+S (S = subtractions).
// Backpressure: none; the scheduler only loads when the core is idle.
//   clk, reset (async active-low), load (1-cycle pulse), a/b operands,
//   done (1-cycle pulse on termination), result (valid while done, held after)
module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      run_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        run_q <= 1'b1;
      end else if (run_q) begin
        // One compare-or-subtract per cycle; the larger operand shrinks,
        // so the subtraction can never wrap.
        if (a_q == '0 || b_q == '0) begin
          result <= a_q | b_q;
          done   <= 1'b1;
          run_q  <= 1'b0;
        end else if (a_q == b_q) begin
          result <= a_q;
          done   <= 1'b1;
          run_q  <= 1'b0;
        end else if (a_q > b_q) begin
          a_q <= a_q - b_q;
        end else begin
          b_q <= b_q - a_q;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Arbitrated GCD server: one shared gcd_core, N_REQ requesters, tagged results.
// Latency: accept edge T -> rsp_valid after edge T+2+S; one IDLE cycle between jobs.
// Backpressure: rsp_valid/data held until rsp_ready; no grants outside IDLE.
//   clk, reset (async active-low), bus (gcd_sched_if.slave: request/response handshakes, busy)
//   Build option GCD_SCHED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  gcd_sched_if.slave  bus
);

  localparam int TW = tag_w(N_REQ);

  state_t           state;
  logic [TW-1:0]    tag_q;
  logic [TW-1:0]    rsp_id_q;
  logic [WIDTH-1:0] rsp_gcd_q;

  logic [TW-1:0]    grant_idx;
  logic             grant_any;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

`ifdef GCD_SCHED_PRIO_EN
  // Fixed priority: scan high to low so the lowest valid index is kept.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        grant_idx = TW'(i);
        grant_any = 1'b1;
      end
    end
  end
`else
  logic [TW-1:0] ptr;

  // Round-robin from ptr: scan offsets high to low so the nearest
  // valid requester at or after ptr is the one that sticks.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (bus.req_valid[idx]) begin
        grant_idx = TW'(idx);
        grant_any = 1'b1;
      end
    end
  end
`endif

  // Grant only in IDLE and never while reset is asserted.
  assign bus.req_ready = (reset && state == IDLE && grant_any)
                       ? (N_REQ'(1) << grant_idx) : '0;
  assign accept = |(bus.req_valid & bus.req_ready);
  assign sel_a  = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b  = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];

  gcd_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .a      (sel_a),
    .b      (sel_b),
    .done   (core_done),
    .result (core_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tag_q     <= '0;
      rsp_id_q  <= '0;
      rsp_gcd_q <= '0;
`ifndef GCD_SCHED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            tag_q <= grant_idx;
`ifndef GCD_SCHED_PRIO_EN
            ptr   <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        RUN: begin
          if (core_done) begin
            state     <= RESP;
            rsp_id_q  <= tag_q;
            rsp_gcd_q <= core_result;
          end
        end
        RESP: begin
          // Return to IDLE; the next grant waits for that IDLE cycle.
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_gcd   = rsp_gcd_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/gcd_sched.md
# gcd_sched

Arbitrated GCD server: shares one iterative GCD datapath between `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request at a time, runs the subtractive Euclid datapath to completion, and returns the result tagged with the requester index. It sits between the requesting clients and the GCD engine, and replaces ad-hoc load/enable pulsing of the core.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand/result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B, same packing.
- `req_ready`  out  N_REQ  one-hot grant/accept; at most one bit is high.
- `rsp_valid`  out  1  result valid.
- `rsp_id`  out  $clog2(N_REQ)  index of the requester that owns the result.
- `rsp_gcd`  out  WIDTH  GCD result.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, RESP.
- IDLE:
  - `req_ready` is driven combinationally to the arbitration winner among the asserted `req_valid` bits.
  - On `req_valid[g] & req_ready[g]`, latch a, b and id=g, then go to RUN.
  - The round-robin pointer becomes (g+1) mod N_REQ.
- RUN, evaluated once per cycle on the registered a and b:
  - if a==0 or b==0: result = a|b, go to RESP.
  - else if a==b: result = a, go to RESP.
  - else if a>b: a <= a−b.
  - else: b <= b−a.
  - All arithmetic is unsigned WIDTH-bit. A subtraction never underflows.
- RESP:
  - `rsp_valid`=1, with `rsp_id` and `rsp_gcd` held stable.
  - On `rsp_ready`, go to IDLE.
  - No request is accepted in the same cycle as a response handshake.
- Arbitration (default): round-robin starting from the pointer. The pointer resets to 0.
- `req_ready` is all-zero in RUN and RESP.
- A requester that drops `req_valid` before being granted loses nothing. Its request is simply not taken.
- Outputs while in reset: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gcd`=0, `busy`=0.
- Reset mid-operation: the in-flight request is discarded with no response, and the pointer returns to 0.

## Timing
- Accept edge T.
  - RUN is active from T+1.
  - Each subtraction costs one cycle.
  - The terminating check costs one cycle.
  - `rsp_valid` rises at T+2+S, where S is the number of subtractions.
- Minimum latency is 2 cycles: equal or zero operands.
- Worst case for WIDTH=8 is S=254, for example (255,1).
- Throughput: one result per (3+S+backpressure) cycles. The IDLE cycle is mandatory.
- `rsp_valid` stays asserted until a `rsp_ready` handshake. Output data does not change while waiting.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep `req_valid` asserted and are served in later rounds.

## Configuration
- `GCD_SCHED_PRIO_EN` defined: fixed priority, lowest index wins. There is no pointer register, and starvation of high indices is permitted.
- `GCD_SCHED_PRIO_EN` undefined: round-robin as specified above.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package `gcd_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, RESP=2'd2);
  - the default `WIDTH`;
  - the result-tag width function.
- One sub-module, `gcd_core`:
  - Ports: `clk`, `reset`, `load`, `a`, `b`, `done`, `result`.
  - Contains the registered a/b and the subtract/compare datapath.
  - `load` is a one-cycle pulse from the scheduler on accept.
  - `done` is a one-cycle pulse when the terminating check fires.
  - The scheduler owns arbitration, the tag, the FSM and the response register.

## Test plan
- Single request, requester 0, (200,68), `rsp_ready`=1 → `rsp_gcd`=4, `rsp_id`=0, `rsp_valid` exactly 20 cycles after the accept edge (S=18).
- Zero and equal operands: (0,45) → 45, (0,0) → 0, (12,12) → 12. Each has `rsp_valid` 2 cycles after accept.
- All four requesters valid continuously, with (120,40), (200,250), (21,24), (153,18) → grant order 0,1,2,3,0. Results are 40, 50, 3, 9 with matching `rsp_id`.
- Backpressure: hold `rsp_ready` low for 5 cycles after (255,2) completes → `rsp_gcd`=1 stays stable, `req_ready`=0 throughout, release is followed by an IDLE cycle before the next grant.
- Assert `reset` low mid-RUN on (255,1) → all outputs go 0 immediately, no response after release, and the next grant starts from requester 0.
- With `GCD_SCHED_PRIO_EN` defined, requesters 0 and 2 valid continuously → requester 0 is granted every time and requester 2 is never granted.
